// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaled period counter (edge- or
// centre-aligned), per-channel duty and polarity, with double-buffered
// period/duty/center updates that take effect only at a period boundary.
module pwm_multi #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [PRESCALE_W-1:0]       prescale,
  input  logic [WIDTH-1:0]            period,
  input  logic [CHANNELS*WIDTH-1:0]   duty,
  input  logic                        center,
  input  logic                        duty_load,
  input  logic [CHANNELS-1:0]         invert,
  output logic [CHANNELS-1:0]         pwm_out,
  output logic                        period_tick,
  output logic                        load_pending
);

  localparam int unsigned DUTY_W = CHANNELS * WIDTH;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Counter state
  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic [WIDTH-1:0]      r_cnt;
  dir_e                  r_dir;

  // Active and shadow configuration
  logic [WIDTH-1:0]      r_period_a;
  logic [WIDTH-1:0]      r_period_s;
  logic [DUTY_W-1:0]     r_duty_a;
  logic [DUTY_W-1:0]     r_duty_s;
  logic                  r_center_a;
  logic                  r_center_s;
  logic                  r_pending;

  // Registered outputs
  logic [CHANNELS-1:0]   r_pwm;
  logic                  r_tick;

  // Next-state signals
  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_apply;
  logic [PRESCALE_W-1:0] w_pre_nxt;
  logic [WIDTH-1:0]      w_cnt_nxt;
  dir_e                  w_dir_nxt;
  logic                  w_pending_nxt;
  logic [CHANNELS-1:0]   w_raw;
  logic [CHANNELS-1:0]   w_pwm_nxt;

  assign w_tick = (r_pre_cnt == prescale);

  // Prescaler and period counter next state, wrap detection, shadow apply
  always_comb begin
    w_pre_nxt = r_pre_cnt;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    w_wrap    = 1'b0;
    w_apply   = 1'b0;
    if (!enable) begin
      w_pre_nxt = '0;
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
      w_apply   = r_pending;
    end else begin
      w_pre_nxt = w_tick ? '0 : (r_pre_cnt + PRESCALE_W'(1));
      if (w_tick) begin
        if (!r_center_a) begin
          if (r_cnt == r_period_a) begin
            w_cnt_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
          end
        end else if (r_period_a == '0) begin
          // Degenerate centre period: counter parks at 0, every tick wraps
          w_cnt_nxt = '0;
          w_dir_nxt = DIR_UP;
          w_wrap    = 1'b1;
        end else if (r_dir == DIR_UP) begin
          if (r_cnt < r_period_a) begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
          end else begin
            w_cnt_nxt = r_period_a - WIDTH'(1);
            w_dir_nxt = DIR_DOWN;
          end
        end else begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - WIDTH'(1);
          end else begin
            w_cnt_nxt = WIDTH'(1);
            w_dir_nxt = DIR_UP;
            w_wrap    = 1'b1;
          end
        end
      end
      w_apply = w_wrap & r_pending;
      if (w_apply) begin
        // New configuration always starts a fresh period from zero
        w_cnt_nxt = '0;
        w_dir_nxt = DIR_UP;
      end
    end
    // A load coinciding with an apply refills the shadow, so stay pending
    if (duty_load) begin
      w_pending_nxt = 1'b1;
    end else if (w_apply) begin
      w_pending_nxt = 1'b0;
    end else begin
      w_pending_nxt = r_pending;
    end
  end

  // Per-channel compare and polarity; idle level is the polarity itself
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_raw[i] = (r_cnt < r_duty_a[i*WIDTH +: WIDTH]);
    end
    w_pwm_nxt = enable ? (w_raw ^ invert) : invert;
  end

  // Counter, direction and prescaler registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre_cnt <= '0;
      r_cnt     <= '0;
      r_dir     <= DIR_UP;
    end else begin
      r_pre_cnt <= w_pre_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dir     <= w_dir_nxt;
    end
  end

  // Shadow capture, active update and pending flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_period_a <= '1;
      r_period_s <= '1;
      r_duty_a   <= '0;
      r_duty_s   <= '0;
      r_center_a <= 1'b0;
      r_center_s <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      if (w_apply) begin
        r_period_a <= r_period_s;
        r_duty_a   <= r_duty_s;
        r_center_a <= r_center_s;
      end
      if (duty_load) begin
        r_period_s <= period;
        r_duty_s   <= duty;
        r_center_s <= center;
      end
      r_pending <= w_pending_nxt;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwm  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pwm  <= w_pwm_nxt;
      r_tick <= w_wrap;
    end
  end

  assign pwm_out      = r_pwm;
  assign period_tick  = r_tick;
  assign load_pending = r_pending;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: phase-based reference model compared
// every cycle, directed scenarios with literal expectations, then random runs.
module tb_pwm_multi;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b0;
  logic [PW-1:0]   prescale = '0;
  logic [W-1:0]    period = '0;
  logic [CH*W-1:0] duty = '0;
  logic            center = 1'b0;
  logic            duty_load = 1'b0;
  logic [CH-1:0]   invert = '0;
  logic [CH-1:0]   pwm_out;
  logic            period_tick;
  logic            load_pending;

  int errors = 0;
  int checks = 0;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .prescale(prescale),
    .period(period), .duty(duty), .center(center), .duty_load(duty_load),
    .invert(invert), .pwm_out(pwm_out), .period_tick(period_tick),
    .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in the period is a tick count q since the period (re)started;
  // the counter value is derived from q arithmetically.
  int m_pre, m_q, m_pa, m_ca, m_ps, m_cs, m_pending;
  int m_da[CH];
  int m_ds[CH];
  logic [CH-1:0] e_pwm;
  logic e_tick, e_pending;

  function automatic int cnt_of(input int q, input int pa, input int ca);
    int m;
    if (ca == 0) return q;
    if (pa == 0) return 0;
    m = q % (2 * pa);
    return (m <= pa) ? m : (2 * pa - m);
  endfunction

  task automatic model_reset();
    m_pre = 0; m_q = 0; m_pa = 255; m_ca = 0; m_ps = 255; m_cs = 0;
    m_pending = 0;
    for (int i = 0; i < CH; i++) begin m_da[i] = 0; m_ds[i] = 0; end
    e_pwm = '0; e_tick = 1'b0; e_pending = 1'b0;
  endtask

  task automatic model_step();
    int c;
    bit tk, wrap, apply;
    wrap = 0;
    if (enable) begin
      c = cnt_of(m_q, m_pa, m_ca);
      for (int i = 0; i < CH; i++) e_pwm[i] = (c < m_da[i]) ^ invert[i];
      tk = (m_pre == int'(prescale));
      m_pre = tk ? 0 : (m_pre + 1) % 256;
      if (tk) begin
        if (m_ca == 0) begin
          wrap = (m_q == m_pa);
          m_q = wrap ? 0 : m_q + 1;
        end else if (m_pa == 0) begin
          wrap = 1; m_q = 0;
        end else begin
          wrap = (m_q > 0) && (m_q % (2 * m_pa) == 0);
          m_q++;
          if (m_q > 2 * m_pa) m_q -= 2 * m_pa;
        end
      end
      apply = wrap && (m_pending != 0);
    end else begin
      m_pre = 0; m_q = 0; e_pwm = invert;
      apply = (m_pending != 0);
    end
    e_tick = wrap;
    if (apply) begin
      m_pa = m_ps; m_ca = m_cs; m_q = 0;
      for (int i = 0; i < CH; i++) m_da[i] = m_ds[i];
    end
    if (duty_load) m_pending = 1;
    else if (apply) m_pending = 0;
    if (duty_load) begin
      m_ps = int'(period); m_cs = int'(center);
      for (int i = 0; i < CH; i++) m_ds[i] = int'(duty[i*W +: W]);
    end
    e_pending = (m_pending != 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("pwm_out", 32'(pwm_out), 32'(e_pwm));
        check("period_tick", 32'(period_tick), 32'(e_tick));
        check("load_pending", 32'(load_pending), 32'(e_pending));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_duty(input int d0, input int d1);
    duty = {W'(d1), W'(d0)};
  endtask

  task automatic cfg(input int ps, input int per, input int ctr, input int d0, input int d1);
    @(negedge clk);
    enable = 1'b0; prescale = PW'(ps); period = W'(per); center = ctr[0];
    set_duty(d0, d1); duty_load = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (period_tick === 1'b1) ok = 1;
    end
    if (!ok) check("wait_tick_timeout", 32'(ok), 32'd1);
  endtask

  task automatic count(input int n, output int h0, output int h1, output int tk);
    h0 = 0; h1 = 0; tk = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]); tk += int'(period_tick);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h0, h1, tk;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_tick", 32'(period_tick), 32'd0);
    check("reset_pending", 32'(load_pending), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Edge mode: period 9, ch0 duty 3, ch1 duty 10 (over period)
    cfg(0, 9, 0, 3, 10);
    wait_tick();
    count(20, h0, h1, tk);
    check("edge_ch0_high", 32'(h0), 32'd6);
    check("edge_ch1_high", 32'(h1), 32'd20);
    check("edge_ticks", 32'(tk), 32'd2);

    // Prescaler: 4 clks per tick, period 1, duty 1
    cfg(3, 1, 0, 1, 1);
    wait_tick();
    count(16, h0, h1, tk);
    check("pre_ch0_high", 32'(h0), 32'd8);
    check("pre_ticks", 32'(tk), 32'd2);

    // Centre mode: period 4, duty 2 -> 3 of 8; duty 5 -> 100 %
    cfg(0, 4, 1, 2, 5);
    wait_tick(); wait_tick();
    count(16, h0, h1, tk);
    check("ctr_ch0_high", 32'(h0), 32'd6);
    check("ctr_ch1_high", 32'(h1), 32'd16);
    check("ctr_ticks", 32'(tk), 32'd2);

    // Mid-period load: duty 3 -> 7 issued at cnt 5
    cfg(0, 9, 0, 3, 10);
    wait_tick();
    h0 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      h0 += int'(pwm_out[0]);
      if (k == 5) begin set_duty(7, 10); duty_load = 1'b1; end
      if (k == 6) begin
        duty_load = 1'b0;
        check("mid_pending_set", 32'(load_pending), 32'd1);
      end
    end
    check("mid_old_duty", 32'(h0), 32'd3);
    check("mid_wrap_tick", 32'(period_tick), 32'd1);
    check("mid_pending_clr", 32'(load_pending), 32'd0);
    count(10, h0, h1, tk);
    check("mid_new_duty", 32'(h0), 32'd7);

    // Load coincident with wrap, ch1 inverted
    invert = 2'b10;
    wait_tick();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) begin set_duty(4, 10); duty_load = 1'b1; end
      if (k == 4) duty_load = 1'b0;
      if (k == 9) begin set_duty(6, 2); duty_load = 1'b1; end
      if (k == 10) duty_load = 1'b0;
    end
    check("coin_tick", 32'(period_tick), 32'd1);
    check("coin_pending_kept", 32'(load_pending), 32'd1);
    count(10, h0, h1, tk);
    check("coin_a_ch0", 32'(h0), 32'd4);
    check("coin_a_ch1_inv", 32'(h1), 32'd0);
    check("coin_b_pending_clr", 32'(load_pending), 32'd0);
    count(10, h0, h1, tk);
    check("coin_b_ch0", 32'(h0), 32'd6);
    check("coin_b_ch1_inv", 32'(h1), 32'd8);

    // Asynchronous reset mid-period, release while disabled
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'd0);
    check("async_rst_tick", 32'(period_tick), 32'd0);
    enable = 1'b0; invert = 2'b01;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("dis_pwm_inv", 32'(pwm_out), 32'd1);
    check("dis_tick", 32'(period_tick), 32'd0);

    // Randomised segments against the model
    for (int s = 0; s < 30; s++) begin
      cfg($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 1),
          $urandom_range(0, 14), $urandom_range(0, 14));
      invert = CH'($urandom);
      for (int k = 0, n = $urandom_range(60, 150); k < n; k++) begin
        @(negedge clk);
        duty_load = 1'b0;
        if ($urandom_range(0, 19) == 0) begin
          period = W'($urandom_range(0, 12));
          center = 1'($urandom_range(0, 1));
          set_duty($urandom_range(0, 14), $urandom_range(0, 14));
          duty_load = 1'b1;
        end
        if ($urandom_range(0, 59) == 0) enable = ~enable;
        else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
        if ($urandom_range(0, 99) == 0) invert = CH'($urandom);
      end
      @(negedge clk);
      duty_load = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
